// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: defaults, NOP word,
// queue entry layout and counter sizing.
package fetch_queue_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP          = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } fq_entry_t;

   // Counters must hold the value DEPTH itself, not just DEPTH-1.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Circular-buffer FIFO with synchronous reset, flush and occupancy count.
// Push when full and pop when empty are ignored.
module sync_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [CW-1:0]     occ
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [AW-1:0]                wptr_q, rptr_q;
   logic [CW-1:0]                occ_q;
   logic                         do_push, do_pop;

   assign do_push = push && (occ_q != CW'(DEPTH));
   assign do_pop  = pop && (occ_q != '0);
   assign rdata   = mem_q[rptr_q];
   assign occ     = occ_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         occ_q <= occ_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: occupancy alone decides what is readable.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: credit-limited in-order requests to
// instruction memory, buffered responses with PC+4, flush on redirect.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        startin,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        deq,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc4
);

   localparam int          CW  = cnt_w(DEPTH);
   localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   ret_pc_q, ret_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] occ;
   logic [CW:0]   credit;
   logic          grant, stale, push, pop;
   fq_entry_t     wr_ent, rd_ent;

   // Queued plus in-flight never exceeds DEPTH, so a push always finds room.
   assign credit  = {1'b0, occ} + {1'b0, outst_q};
   assign mem_req = !startin && !redirect && (credit < CAP);
   assign mem_addr = fetch_pc_q;

   assign grant = mem_req && mem_gnt;
   assign stale = mem_rvalid && (drop_q != '0);
   assign push  = mem_rvalid && !stale && !redirect;
   assign pop   = deq && inst_valid && !redirect;

   assign wr_ent = '{inst: mem_rdata, pc4: ret_pc_q + 32'd4};

   sync_fifo #(
      .DATA_W ($bits(fq_entry_t)),
      .DEPTH  (DEPTH),
      .CW     (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (startin),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata (wr_ent),
      .rdata (rd_ent),
      .occ   (occ)
   );

   assign inst_valid = (occ != '0);
   assign inst       = inst_valid ? rd_ent.inst : NOP;
   assign inst_pc4   = inst_valid ? rd_ent.pc4  : 32'h0;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      ret_pc_d   = ret_pc_q;
      outst_d    = outst_q + CW'(grant) - CW'(mem_rvalid);
      drop_d     = drop_q;
      if (stale) drop_d     = drop_q - CW'(1);
      if (push)  ret_pc_d   = ret_pc_q + 32'd4;
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      // Everything still outstanding after this cycle belongs to the old stream.
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         ret_pc_d   = redirect_pc;
         drop_d     = outst_d;
      end
   end

   always_ff @(posedge clk) begin
      if (startin) begin
         fetch_pc_q <= RESET_PC;
         ret_pc_q   <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         ret_pc_q   <= ret_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order instruction memory model
// whose word at address A is ~A and whose latency is set per phase.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        startin = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        deq = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b1;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc4;

   int checks = 0;
   int errors = 0;
   int lat = 1;

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .startin     (startin),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .deq         (deq),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc4    (inst_pc4)
   );

   always #5 clk = ~clk;

   // Memory: grants seen before an edge return lat cycles later, in order.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;
   rsp_t rq[$];
   int   mcnt = 0;

   initial begin
      logic        s_rst, s_g, s_r;
      logic [31:0] s_a;
      forever begin
         @(negedge clk);
         s_rst = startin;
         s_g   = mem_req && mem_gnt;
         s_a   = mem_addr;
         s_r   = mem_rvalid;
         @(posedge clk);
         #1;
         mcnt++;
         if (s_rst) rq.delete();
         else begin
            if (s_r && rq.size() > 0) void'(rq.pop_front());
            if (s_g) rq.push_back('{s_a, mcnt + lat - 1});
         end
         if (rq.size() > 0 && rq[0].due <= mcnt) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ~rq[0].addr;
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      startin = 1'b1;
      next();
      next();
      startin = 1'b0;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int nreq;

      // Reset state
      startin = 1'b1; deq = 1'b1; mem_gnt = 1'b1; lat = 1;
      next(); next();
      samp();
      chk("rst_req",   32'(mem_req),    32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst",  inst,            32'h0);
      chk("rst_pc4",   inst_pc4,        32'h0);
      next();
      startin = 1'b0;

      // L=1 streaming with deq held high
      for (int k = 1; k <= 6; k++) begin
         samp();
         chk("s_req",  32'(mem_req), 32'd1);
         chk("s_addr", mem_addr, 32'(4 * (k - 1)));
         if (k >= 3) begin
            chk("s_valid", 32'(inst_valid), 32'd1);
            chk("s_pc4",   inst_pc4, 32'(4 * (k - 2)));
            chk("s_inst",  inst, ~(32'(4 * (k - 3))));
         end else begin
            chk_empty("s_early");
         end
         next();
      end

      // Credit limit with deq held low
      deq = 1'b0; lat = 1;
      do_reset();
      nreq = 0;
      for (int k = 1; k <= 6; k++) begin
         samp();
         if (mem_req) nreq++;
         next();
      end
      chk("cr_grants", 32'(nreq), 32'd4);
      deq = 1'b1;
      samp();
      chk("cr_full_req", 32'(mem_req), 32'd0);
      chk("cr_full_pc4", inst_pc4, 32'd4);
      chk("cr_full_inst", inst, ~32'h0);
      next();
      deq = 1'b0;
      samp();
      chk("cr_restart_req",  32'(mem_req), 32'd1);
      chk("cr_restart_addr", mem_addr, 32'd16);
      chk("cr_head_pc4",     inst_pc4, 32'd8);
      next();

      // L=3, two requests in flight, redirect to 0x100
      lat = 3; deq = 1'b0;
      do_reset();
      next();
      next();
      redirect = 1'b1; redirect_pc = 32'h100;
      samp();
      chk("rd_req_blocked", 32'(mem_req), 32'd0);
      next();
      redirect = 1'b0;
      samp();
      chk_empty("rd_n1");
      chk("rd_req",  32'(mem_req), 32'd1);
      chk("rd_addr", mem_addr, 32'h100);
      next();
      for (int k = 5; k <= 7; k++) begin
         samp();
         chk_empty("rd_stale");
         next();
      end
      samp();
      chk("rd_valid", 32'(inst_valid), 32'd1);
      chk("rd_pc4",   inst_pc4, 32'h104);
      chk("rd_inst",  inst, ~32'h100);
      next();

      // Redirect coinciding with rvalid and deq; one stale response left
      lat = 3; deq = 1'b1;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         samp();
         if (k == 5) chk("co_credit_block", 32'(mem_req), 32'd0);
         next();
      end
      redirect = 1'b1; redirect_pc = 32'h300;
      samp();
      chk("co_rvalid_now", 32'(mem_rvalid), 32'd1);
      next();
      redirect = 1'b0;
      samp();
      chk_empty("co_n1");
      chk("co_addr", mem_addr, 32'h300);
      next();
      for (int k = 9; k <= 11; k++) begin
         samp();
         chk_empty("co_stale");
         next();
      end
      samp();
      chk("co_valid", 32'(inst_valid), 32'd1);
      chk("co_pc4",   inst_pc4, 32'h304);
      chk("co_inst",  inst, ~32'h300);
      next();

      // Push+pop at occ=2, then deq on an empty queue
      lat = 1; deq = 1'b0;
      do_reset();
      next(); next(); next();
      deq = 1'b1;
      next();
      deq = 1'b0;
      samp();
      chk("pp_occ",  32'(dut.occ), 32'd2);
      chk("pp_pc4",  inst_pc4, 32'd8);
      chk("pp_inst", inst, ~32'd4);
      next();
      next();
      redirect = 1'b1; redirect_pc = 32'h400;
      next();
      redirect = 1'b0; deq = 1'b1;
      samp();
      chk_empty("de_n1");
      chk("de_addr", mem_addr, 32'h400);
      next();
      samp();
      chk_empty("de_n2");
      next();
      deq = 1'b0;
      startin = 1'b1;
      samp();
      chk("de_valid", 32'(inst_valid), 32'd1);
      chk("de_pc4",   inst_pc4, 32'h404);
      chk("de_inst",  inst, ~32'h400);
      next();

      // Reset mid-stream with an entry queued
      samp();
      chk("mr_req",   32'(mem_req),    32'd0);
      chk("mr_valid", 32'(inst_valid), 32'd0);
      chk("mr_inst",  inst,            32'h0);
      chk("mr_pc4",   inst_pc4,        32'h0);
      next();
      startin = 1'b0;
      samp();
      chk("mr_restart_req",  32'(mem_req), 32'd1);
      chk("mr_restart_addr", mem_addr, 32'h0);
      next();
      next();
      samp();
      chk("mr_pc4_after", inst_pc4, 32'd4);
      chk("mr_inst_after", inst, ~32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
